pixel_sink: RTL and testbench
=============================

# pixel_sink

Receiving end of the sprite pixel-write stream. Sprite drawers such as the platform, ball and bricks each emit one pixel per cycle as x, y, colour plus a write enable. pixel_sink accepts those writes, drops off-screen coordinates, buffers them in a small FIFO and replays them to the 160x120 VGA adapter plot port. It also owns the full-screen clear sweep, which takes priority over buffered pixels.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 2.
- X_MAX, 159: largest legal x.
- Y_MAX, 119: largest legal y.
- CLEAR_COLOUR, 3'b000: colour written by the clear sweep.
- clk  in  1  single clock; all state updates on its rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- in_wren  in  1  pixel write request from a drawer.
- in_x  in  10  requested x.
- in_y  in  10  requested y.
- in_colour  in  3  requested colour.
- in_ready  out  1  high when a write will be accepted; equals !full.
- out_x  out  8  x to the VGA adapter.
- out_y  out  7  y to the VGA adapter.
- out_colour  out  3  colour to the VGA adapter.
- out_plot  out  1  one-cycle plot strobe; registered.
- out_ready  in  1  adapter may take a pixel this cycle; tie to 1 if the adapter never stalls.
- clear_req  in  1  start a full-screen clear; sampled on a single cycle.
- clear_busy  out  1  high while the clear sweep runs.
- fifo_count  out  log2(DEPTH)+1  current number of FIFO entries.
- drop_count  out  8  saturating count of discarded off-screen pixels.

## Operation
- Accept: a write is accepted on a rising edge when in_wren && in_ready.
- In-range rule: in_x <= X_MAX and in_y <= Y_MAX.
  - An accepted in-range pixel is pushed with x truncated to 8 bits and y to 7 bits.
  - An accepted out-of-range pixel is discarded and drop_count increments, saturating at 255.
  - A write offered while full is not accepted and is not counted, whatever its coordinates.
- FIFO: circular buffer of DEPTH entries, strict arrival order.
  - Full when fifo_count == DEPTH.
  - in_ready is decoded from the registered count only, so no push ever occurs when full, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave fifo_count unchanged.
- States:
  - IDLE to CLEAR on clear_req. clear_req takes effect from IDLE only; it is ignored while in CLEAR.
  - CLEAR to IDLE after pixel (X_MAX, Y_MAX) has been issued.
- IDLE: on each edge where fifo_count > 0 and out_ready = 1, pop the head into out_x, out_y, out_colour and set out_plot = 1. Otherwise out_plot = 0 and the output registers hold their values.
- CLEAR: on each edge with out_ready = 1, issue (cx, cy, CLEAR_COLOUR) with out_plot = 1, then advance.
  - cx increments fastest, wrapping 0..X_MAX; cy increments on each cx wrap.
  - cx and cy restart at 0 on every clear.
  - With out_ready = 0: out_plot = 0, counters hold.
  - The FIFO does not pop during CLEAR but still accepts writes up to full.
- clear_busy is high throughout CLEAR, including the edge on which the final pixel is issued.
- Reset (asynchronous, any state, including mid-clear or mid-drain):
  - State to IDLE, FIFO emptied.
  - out_x = 0, out_y = 0, out_colour = 0, out_plot = 0.
  - in_ready = 1, fifo_count = 0, drop_count = 0, clear_busy = 0, cx = cy = 0.

## Timing
- Latency, FIFO empty, IDLE, out_ready = 1: write presented in cycle k appears with out_plot = 1 in cycle k+2.
- Throughput: one pixel per cycle in steady state, in and out.
- Clear duration: (X_MAX+1)*(Y_MAX+1) = 19200 out_ready cycles.
  - clear_busy rises in the cycle after clear_req is sampled.
  - clear_busy falls in the cycle after the last clear pixel is issued.
- Pending FIFO pixels drain starting the cycle after CLEAR exits, so sprites drawn during a clear land on top of it.
- out_plot is never high for two consecutive cycles with the same FIFO entry; each entry is plotted exactly once.

## Test plan
- Reset then single write, x=32 y=110 colour=3'b100 in cycle 0: out_plot=1 in cycle 2 with out_x=32, out_y=110, out_colour=4; fifo_count back to 0.
- Burst of 12 writes x=0..11 with out_ready=0: in_ready falls after 8 accepts, writes 9-12 refused, fifo_count=8. Raise out_ready: x=0..7 plotted in order on 8 consecutive cycles, then in_ready=1.
- Writes (160,5), (5,120) and (159,119): drop_count=2; only (159,119) plotted. 300 off-screen writes: drop_count saturates at 255.
- clear_req with 3 pixels queued and out_ready=1: 19200 plots of colour 0 from (0,0) to (159,119), x fastest, clear_busy high throughout; the 3 queued pixels plot immediately after. A second clear_req mid-sweep is ignored.
- Simultaneous push and pop at fifo_count=4 over 20 cycles: fifo_count stays 4; output order matches input order.
- Assert resetn=0 mid-clear at pixel (70,40) and mid-drain with 5 entries: all outputs take reset values immediately (asynchronously); the next write plots with 2-cycle latency and no stale pixel appears.

Source files
------------

// File: rtl/pixel_sink.sv
// Sprite pixel sink: filters off-screen writes, queues them in a small FIFO and
// replays them to the VGA plot port; a full-screen clear sweep has priority.
module pixel_sink #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned X_MAX        = 159,
    parameter int unsigned Y_MAX        = 119,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_wren,
    input  logic [9:0]               in_x,
    input  logic [9:0]               in_y,
    input  logic [2:0]               in_colour,
    output logic                     in_ready,
    output logic [7:0]               out_x,
    output logic [6:0]               out_y,
    output logic [2:0]               out_colour,
    output logic                     out_plot,
    input  logic                     out_ready,
    input  logic                     clear_req,
    output logic                     clear_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [0:0]    state_q;
    logic [7:0]    cx_q;
    logic [6:0]    cy_q;
    logic [7:0]    drop_q;
    logic [7:0]    out_x_q;
    logic [6:0]    out_y_q;
    logic [2:0]    out_colour_q;
    logic          out_plot_q;

    logic in_range, accept, push, drop, pop, clr_issue, cx_last, cy_last;

    // Ready depends only on the registered count, so a same-cycle pop never
    // opens a slot for a push.
    assign in_ready  = (count_q != (AW+1)'(DEPTH));
    assign in_range  = (in_x <= 10'(X_MAX)) && (in_y <= 10'(Y_MAX));
    assign accept    = in_wren && in_ready;
    assign push      = accept && in_range;
    assign drop      = accept && !in_range;
    assign pop       = (state_q == S_IDLE) && !clear_req && (count_q != '0) && out_ready;
    assign clr_issue = (state_q == S_CLEAR) && out_ready;
    assign cx_last   = (cx_q == 8'(X_MAX));
    assign cy_last   = (cy_q == 7'(Y_MAX));

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, so clearing the contents would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_x[7:0], in_y[6:0], in_colour};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear_req) begin
                        state_q <= S_CLEAR;
                        cx_q    <= '0;
                        cy_q    <= '0;
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (cx_last) begin
                            cx_q <= '0;
                            if (cy_last) begin
                                cy_q    <= '0;
                                state_q <= S_IDLE;
                            end else begin
                                cy_q <= cy_q + 7'd1;
                            end
                        end else begin
                            cx_q <= cx_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_colour_q <= '0;
            out_plot_q   <= 1'b0;
        end else begin
            out_plot_q <= pop || clr_issue;
            if (pop) begin
                {out_x_q, out_y_q, out_colour_q} <= mem[rd_ptr_q];
            end else if (clr_issue) begin
                out_x_q      <= cx_q;
                out_y_q      <= cy_q;
                out_colour_q <= CLEAR_COLOUR;
            end
        end
    end

    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_colour = out_colour_q;
    assign out_plot   = out_plot_q;
    assign clear_busy = (state_q == S_CLEAR);
    assign fifo_count = count_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink: a queue-based reference model compared
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_pixel_sink;

    localparam int DEPTH = 8;
    localparam int XM    = 159;
    localparam int YM    = 119;
    localparam int NPIX  = (XM + 1) * (YM + 1);

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_wren = 1'b0;
    logic [9:0] in_x = '0;
    logic [9:0] in_y = '0;
    logic [2:0] in_colour = '0;
    logic       in_ready;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       out_plot;
    logic       out_ready = 1'b1;
    logic       clear_req = 1'b0;
    logic       clear_busy;
    logic [3:0] fifo_count;
    logic [7:0] drop_count;

    pixel_sink #(.DEPTH(DEPTH), .X_MAX(XM), .Y_MAX(YM), .CLEAR_COLOUR(3'b000)) dut (
        .clk(clk), .resetn(resetn),
        .in_wren(in_wren), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .in_ready(in_ready),
        .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .out_plot(out_plot),
        .out_ready(out_ready), .clear_req(clear_req), .clear_busy(clear_busy),
        .fifo_count(fifo_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    // Reference model: pending pixels in a queue, the clear sweep as a linear index.
    pix_t m_q[$];
    int   m_drop;
    bit   m_clear;
    int   m_idx;
    pix_t m_out;
    bit   m_plot;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_drop  = 0;
        m_clear = 0;
        m_idx   = 0;
        m_out   = '0;
        m_plot  = 0;
    endfunction

    function automatic void model_step();
        int   cnt = m_q.size();
        bit   do_push = 0;
        pix_t nw = '0;
        if (in_wren && cnt < DEPTH) begin
            if (int'(in_x) <= XM && int'(in_y) <= YM) begin
                do_push = 1;
                nw = '{x: in_x[7:0], y: in_y[6:0], c: in_colour};
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        m_plot = 0;
        if (m_clear) begin
            if (out_ready) begin
                m_out  = '{x: 8'(m_idx % (XM + 1)), y: 7'(m_idx / (XM + 1)), c: 3'b000};
                m_plot = 1;
                m_idx++;
                if (m_idx == NPIX) m_clear = 0;
            end
        end else if (clear_req) begin
            m_clear = 1;
            m_idx   = 0;
        end else if (cnt > 0 && out_ready) begin
            m_out  = m_q.pop_front();
            m_plot = 1;
        end
        if (do_push) m_q.push_back(nw);
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else         model_step();
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        logic [32:0] dut_v, exp_v;
        forever begin
            @(negedge clk);
            dut_v = {in_ready, fifo_count, drop_count, clear_busy, out_plot, out_x, out_y, out_colour};
            exp_v = {m_q.size() < DEPTH, 4'(m_q.size()), 8'(m_drop), m_clear, m_plot, m_out};
            check("cycle outputs", 64'(dut_v), 64'(exp_v));
        end
    end

    task automatic drive(input logic w, input int x, input int y, input int c);
        in_wren   = w;
        in_x      = 10'(x);
        in_y      = 10'(y);
        in_colour = 3'(c);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " out_plot"}, out_plot, 0);
        check({tag, " out_x"}, out_x, 0);
        check({tag, " out_y"}, out_y, 0);
        check({tag, " out_colour"}, out_colour, 0);
        check({tag, " in_ready"}, in_ready, 1);
        check({tag, " fifo_count"}, fifo_count, 0);
        check({tag, " drop_count"}, drop_count, 0);
        check({tag, " clear_busy"}, clear_busy, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        int  busy_cycles;
        bit  found;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        resetn = 1'b1;

        // Single write: 2-cycle latency.
        @(negedge clk); drive(1, 32, 110, 4);
        @(negedge clk); drive(0, 0, 0, 0);
        check("t1 count after push", fifo_count, 1);
        @(negedge clk);
        check("t1 plot", out_plot, 1);
        check("t1 x", out_x, 32);
        check("t1 y", out_y, 110);
        check("t1 colour", out_colour, 4);
        @(negedge clk);
        check("t1 plot low", out_plot, 0);
        check("t1 count empty", fifo_count, 0);

        // Burst of 12 into a stalled adapter.
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1, i, i, i % 8);
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        check("t2 count full", fifo_count, 8);
        check("t2 in_ready low", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2 drain plot", out_plot, 1);
            check("t2 drain order", out_x, i);
        end
        @(negedge clk);
        check("t2 drain done", out_plot, 0);
        check("t2 in_ready high", in_ready, 1);

        // Off-screen filtering and saturation.
        drive(1, 160, 5, 1);   @(negedge clk);
        drive(1, 5, 120, 2);   @(negedge clk);
        drive(1, 159, 119, 7); @(negedge clk);
        drive(0, 0, 0, 0);
        check("t3 drop two", drop_count, 2);
        @(negedge clk);
        check("t3 corner plot", out_plot, 1);
        check("t3 corner xy", {out_x, out_y}, {8'd159, 7'd119});
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) drive(1, $urandom_range(160, 1023), $urandom_range(0, 1023), i);
            else            drive(1, $urandom_range(0, 159), $urandom_range(120, 1023), i);
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        check("t3 drop saturate", drop_count, 255);

        // Simultaneous push and pop holding the count at 4.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 100 + i, 50, i); @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1, i, 60 + i, i); @(negedge clk);
            check("t5 count steady", fifo_count, 4);
        end
        drive(0, 0, 0, 0);
        repeat (6) @(negedge clk);

        // Full-screen clear with 3 pixels queued; writes during the sweep.
        out_ready = 1'b0;
        drive(1, 10, 10, 1); @(negedge clk);
        drive(1, 20, 20, 2); @(negedge clk);
        drive(1, 30, 30, 3); @(negedge clk);
        drive(0, 0, 0, 0);
        out_ready = 1'b1;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        check("t4 busy rises", clear_busy, 1);
        busy_cycles = 1;
        found = 0;
        for (int i = 0; i < NPIX + 100; i++) begin
            clear_req = (busy_cycles == 5000);
            if (busy_cycles >= 100 && busy_cycles < 110) drive(1, busy_cycles - 100, 1, 5);
            else drive(0, 0, 0, 0);
            @(negedge clk);
            if (clear_busy) busy_cycles++;
            else begin found = 1; break; end
        end
        clear_req = 1'b0;
        drive(0, 0, 0, 0);
        check("t4 clear finished", found, 1);
        check("t4 busy cycles", busy_cycles, NPIX);
        check("t4 last clear pixel", {out_plot, out_x, out_y, out_colour}, {1'b1, 8'd159, 7'd119, 3'd0});
        @(negedge clk);
        check("t4 first queued after clear", {out_plot, out_x, out_colour}, {1'b1, 8'd10, 3'd1});
        repeat (10) @(negedge clk);

        // Reset in the middle of a clear at pixel (70,40).
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        found = 0;
        for (int i = 0; i < 40000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_plot && clear_busy && out_x == 8'd70 && out_y == 7'd40) begin found = 1; break; end
        end
        check("t6 reached 70,40", found, 1);
        #2 resetn = 1'b0;
        #1 check_reset_values("t6 async");
        @(negedge clk);
        resetn = 1'b1;
        out_ready = 1'b1;
        drive(1, 44, 55, 6);
        @(negedge clk); drive(0, 0, 0, 0);
        @(negedge clk);
        check("t6 post-reset plot", {out_plot, out_x, out_y, out_colour}, {1'b1, 8'd44, 7'd55, 3'd6});
        @(negedge clk);
        check("t6 no stale", out_plot, 0);

        // Reset in the middle of a drain with 5 entries.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 80 + i, 90, i); @(negedge clk);
        end
        drive(0, 0, 0, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("t7 five left", fifo_count, 5);
        #2 resetn = 1'b0;
        #1 check_reset_values("t7 async");
        @(negedge clk);
        resetn = 1'b1;
        drive(1, 3, 4, 5);
        @(negedge clk); drive(0, 0, 0, 0);
        @(negedge clk);
        check("t7 post-reset plot", {out_plot, out_x, out_y, out_colour}, {1'b1, 8'd3, 7'd4, 3'd5});
        @(negedge clk);
        check("t7 no stale", out_plot, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 200), $urandom_range(0, 150),
                  $urandom_range(0, 7));
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("final empty", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
